// File: rtl/dispmux_n.sv
// dispmux_n: time-multiplexed N-digit 7-segment driver with frame-coherent
// shadow latching, per-digit blank/decimal point, 16-level brightness PWM
// and a frame pulse.
// Optional feature: define DISPMUX_LZB_EN to enable leading-zero blanking.
module dispmux_n #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned PRESCALE_W     = 8,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     seldig,
   output logic [6:0]            disp,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int unsigned      IDX_W    = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [6:0]       SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   dig_sh_q;
   logic [DIGITS-1:0]     dp_sh_q;
   logic [DIGITS-1:0]     blk_sh_q;
   logic [3:0]            br_sh_q;

   logic [DIGITS-1:0]     seldig_q;
   logic [6:0]            disp_q;
   logic                  dp_q;
   logic                  tick_q;

   logic                  cnt_max;
   logic                  frame_end;
   logic [3:0]            nib;
   logic                  dp_cur;
   logic                  blk_cur;
   logic                  lzb_cur;
   logic [DIGITS-1:0]     onehot;
   logic [3:0]            top;
   logic                  pwm_on;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     sel_d;
   logic [6:0]            disp_d;
   logic                  dp_d;

   assign cnt_max   = &cnt_q;
   assign frame_end = cnt_max && (idx_q == IDX_LAST);
   assign top       = cnt_q[PRESCALE_W-1 -: 4];
   assign pwm_on    = (top < br_sh_q);

   // Dwell counter and digit index; idx wraps at DIGITS-1 so unused codes are never visited.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_max) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Select the shadow fields of the current digit by comparison, avoiding out-of-range slices.
   always_comb begin
      nib     = '0;
      dp_cur  = 1'b0;
      blk_cur = 1'b0;
      onehot  = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib       = dig_sh_q[4*k +: 4];
            dp_cur    = dp_sh_q[k];
            blk_cur   = blk_sh_q[k];
            onehot[k] = 1'b1;
         end
      end
   end

`ifdef DISPMUX_LZB_EN
   logic [DIGITS-1:0] lzb_mask;
   logic              zero_run;

   // Digit k is a leading zero when it and every higher nibble are zero; digit 0 never is.
   always_comb begin
      lzb_mask = '0;
      zero_run = 1'b1;
      for (int unsigned j = 0; j < DIGITS - 1; j++) begin
         zero_run                = zero_run & (dig_sh_q[4*(DIGITS-1-j) +: 4] == 4'h0);
         lzb_mask[DIGITS-1-j]    = zero_run;
      end
   end

   assign lzb_cur = |(lzb_mask & onehot);
`else
   assign lzb_cur = 1'b0;
`endif

   // Hex to {g,f,e,d,c,b,a} decode.
   always_comb begin
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
   end

   // Next output values; an LZB-dark digit keeps only its decimal point.
   always_comb begin
      sel_d  = '1;
      disp_d = '0;
      dp_d   = 1'b0;
      if (pwm_on && !blk_cur) begin
         if (!lzb_cur) begin
            sel_d  = ~onehot;
            disp_d = seg;
            dp_d   = dp_cur;
         end else if (dp_cur) begin
            sel_d  = ~onehot;
            dp_d   = 1'b1;
         end
      end
   end

   // State, frame-boundary shadow load and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         dig_sh_q <= digits_in;
         dp_sh_q  <= dp_in;
         blk_sh_q <= blank_in;
         br_sh_q  <= bright;
         seldig_q <= '1;
         disp_q   <= SEG_INV;
         dp_q     <= SEG_ACTIVE_LOW;
         tick_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (frame_end) begin
            dig_sh_q <= digits_in;
            dp_sh_q  <= dp_in;
            blk_sh_q <= blank_in;
            br_sh_q  <= bright;
         end
         seldig_q <= sel_d;
         disp_q   <= disp_d ^ SEG_INV;
         dp_q     <= dp_d ^ SEG_ACTIVE_LOW;
         tick_q   <= frame_end;
      end
   end

   assign seldig     = seldig_q;
   assign disp       = disp_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_dispmux_n.sv
// tb_dispmux_n: self-checking bench for dispmux_n. Two instances share the
// stimulus: DIGITS=4 active-high and DIGITS=3 active-low, both PRESCALE_W=4.
module tb_dispmux_n;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] dig = 16'h0;
   logic [3:0]  dpi = 4'h0;
   logic [3:0]  blk = 4'h0;
   logic [3:0]  br  = 4'h0;

   logic [3:0]  seldig4;
   logic [6:0]  disp4;
   logic        dp4, tick4;
   logic [2:0]  seldig3;
   logic [6:0]  disp3;
   logic        dp3, tick3;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   dispmux_n #(.DIGITS(4), .PRESCALE_W(4), .SEG_ACTIVE_LOW(1'b0)) dut4 (
      .clk(clk), .rst(rst), .digits_in(dig), .dp_in(dpi), .blank_in(blk), .bright(br),
      .seldig(seldig4), .disp(disp4), .dp(dp4), .frame_tick(tick4));

   dispmux_n #(.DIGITS(3), .PRESCALE_W(4), .SEG_ACTIVE_LOW(1'b1)) dut3 (
      .clk(clk), .rst(rst), .digits_in(dig[11:0]), .dp_in(dpi[2:0]), .blank_in(blk[2:0]), .bright(br),
      .seldig(seldig3), .disp(disp3), .dp(dp3), .frame_tick(tick3));

   logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Expected {sel[7:0], disp, dp, tick} for the n-th cycle after reset, from the display rules.
   function automatic logic [16:0] model_out(int unsigned d, int unsigned n, logic [31:0] sdig,
                                             logic [7:0] sdp, logic [7:0] sblk, logic [3:0] sbr,
                                             bit act_low);
      int unsigned c, i;
      logic [3:0]  nb;
      bit          on, lz, tk;
      logic [7:0]  sel;
      logic [6:0]  sg;
      logic        dpo;
      c   = n % 16;
      i   = (n / 16) % d;
      nb  = 4'((sdig >> (4 * i)) & 32'hF);
      on  = (c < int'(sbr)) && !sblk[i];
      lz  = 1'b0;
`ifdef DISPMUX_LZB_EN
      lz  = (i != 0) && ((sdig >> (4 * i)) == 32'h0);
`endif
      sel = 8'hFF;
      sg  = 7'h00;
      dpo = 1'b0;
      if (on && !lz) begin
         sel[i] = 1'b0; sg = SEG_TAB[nb]; dpo = sdp[i];
      end else if (on && sdp[i]) begin
         sel[i] = 1'b0; dpo = 1'b1;
      end
      if (act_low) begin
         sg = ~sg; dpo = ~dpo;
      end
      tk = (n % (16 * d)) == (16 * d - 1);
      return {sel, sg, dpo, tk};
   endfunction

   // Reference model: cycle count since reset plus shadows reloaded every 16*DIGITS cycles.
   int unsigned n_m = 0;
   logic [15:0] s4_dig; logic [3:0] s4_dp, s4_blk, s4_br;
   logic [11:0] s3_dig; logic [2:0] s3_dp, s3_blk; logic [3:0] s3_br;
   logic [16:0] exp4 = '1;
   logic [16:0] exp3 = '1;

   always @(posedge clk) begin
      if (rst) begin
         n_m = 0;
         s4_dig = dig; s4_dp = dpi; s4_blk = blk; s4_br = br;
         s3_dig = dig[11:0]; s3_dp = dpi[2:0]; s3_blk = blk[2:0]; s3_br = br;
         exp4 = {8'hFF, 7'h00, 1'b0, 1'b0};
         exp3 = {8'hFF, 7'h7F, 1'b1, 1'b0};
      end else begin
         exp4 = model_out(4, n_m, {16'h0, s4_dig}, {4'h0, s4_dp}, {4'h0, s4_blk}, s4_br, 1'b0);
         exp3 = model_out(3, n_m, {20'h0, s3_dig}, {5'h0, s3_dp}, {5'h0, s3_blk}, s3_br, 1'b1);
         if (n_m % 64 == 63) begin
            s4_dig = dig; s4_dp = dpi; s4_blk = blk; s4_br = br;
         end
         if (n_m % 48 == 47) begin
            s3_dig = dig[11:0]; s3_dp = dpi[2:0]; s3_blk = blk[2:0]; s3_br = br;
         end
         n_m++;
      end
   end

   logic [6:0] SEG_1234 [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
   logic [6:0] SEG_ABCD [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};

   function automatic int low_pos(logic [3:0] s);
      int p;
      p = -1;
      for (int k = 0; k < 4; k++) if (!s[k]) p = k;
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({seldig4, disp4, dp4, tick4} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
         failures++; $display("FAIL reset_dut4 got=%h exp=%h", {seldig4, disp4, dp4, tick4}, {4'hF, 7'h00, 1'b0, 1'b0});
      end
      checks++;
      if ({seldig3, disp3, dp3, tick3} !== {3'h7, 7'h7F, 1'b1, 1'b0}) begin
         failures++; $display("FAIL reset_dut3 got=%h exp=%h", {seldig3, disp3, dp3, tick3}, {3'h7, 7'h7F, 1'b1, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_frame_1234();
      int lit [4];
      int ticks, p;
      lit = '{0, 0, 0, 0}; ticks = 0;
      dig = 16'h1234; br = 4'd15; dpi = 4'h0; blk = 4'h0;
      do_reset();
      for (int t = 0; t < 128; t++) begin
         @(negedge clk);
         checks++;
         if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
            failures++; $display("FAIL frame1234_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
         end
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL frame1234_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
         if (tick4) ticks++;
         p = low_pos(seldig4);
         if (p >= 0) begin
            lit[p]++;
            checks++;
            if (disp4 !== SEG_1234[p]) begin
               failures++; $display("FAIL frame1234_seg digit=%0d got=%h exp=%h", p, disp4, SEG_1234[p]);
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (lit[k] != 30) begin
            failures++; $display("FAIL frame1234_duty digit=%0d got=%0d exp=30", k, lit[k]);
         end
      end
      checks++;
      if (ticks != 2) begin
         failures++; $display("FAIL frame1234_ticks got=%0d exp=2", ticks);
      end
   endtask

   task automatic test_shadow_midframe();
      int p;
      dig = 16'h1234; br = 4'd15; dpi = 4'h0; blk = 4'h0;
      do_reset();
      for (int t = 0; t < 128; t++) begin
         @(negedge clk);
         checks++;
         if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
            failures++; $display("FAIL shadow_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
         end
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL shadow_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
         p = low_pos(seldig4);
         if (p >= 0) begin
            checks++;
            if (disp4 !== ((t < 64) ? SEG_1234[p] : SEG_ABCD[p])) begin
               failures++; $display("FAIL shadow_tear t=%0d digit=%0d got=%h exp=%h", t, p, disp4,
                                    (t < 64) ? SEG_1234[p] : SEG_ABCD[p]);
            end
         end
         if (t == 20) dig = 16'hABCD;
      end
   endtask

   task automatic test_brightness();
      int lit [4];
      int p;
      dig = 16'h5678; br = 4'd0; dpi = 4'hF; blk = 4'h0;
      do_reset();
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         checks++;
         if ({seldig4, disp4, dp4} !== {4'hF, 7'h00, 1'b0}) begin
            failures++; $display("FAIL bright0 t=%0d got=%h exp=%h", t, {seldig4, disp4, dp4}, {4'hF, 7'h00, 1'b0});
         end
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL bright0_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
      end
      lit = '{0, 0, 0, 0};
      br = 4'd4;
      do_reset();
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         checks++;
         if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
            failures++; $display("FAIL bright4_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
         end
         p = low_pos(seldig4);
         if (p >= 0) lit[p]++;
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (lit[k] != 4) begin
            failures++; $display("FAIL bright4_duty digit=%0d got=%0d exp=4", k, lit[k]);
         end
      end
   endtask

   task automatic test_blank_dp();
      dig = 16'h1234; br = 4'd15; dpi = 4'b0001; blk = 4'b0100;
      do_reset();
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         checks++;
         if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
            failures++; $display("FAIL blankdp_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
         end
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL blankdp_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
         checks++;
         if (seldig4 === 4'b1011 || dp4 !== (seldig4 === 4'b1110)) begin
            failures++; $display("FAIL blankdp_rule t=%0d got_sel=%b got_dp=%b", t, seldig4, dp4);
         end
      end
   endtask

`ifdef DISPMUX_LZB_EN
   task automatic test_lzb();
      int p;
      br = 4'd15; dpi = 4'h0; blk = 4'h0;
      for (int phase = 0; phase < 2; phase++) begin
         dig = (phase == 0) ? 16'h0070 : 16'h0000;
         do_reset();
         for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            checks++;
            if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
               failures++; $display("FAIL lzb_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
            end
            p = low_pos(seldig4);
            if (p >= 0) begin
               checks++;
               if (p > ((phase == 0) ? 1 : 0) || disp4 !== ((p == 1) ? 7'h07 : 7'h3F)) begin
                  failures++; $display("FAIL lzb_rule phase=%0d digit=%0d got=%h", phase, p, disp4);
               end
            end
         end
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [2:0] seq [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
      dig = 16'h1234; br = 4'd15; dpi = 4'h0; blk = 4'h0;
      do_reset();
      for (int t = 0; t < 37; t++) begin
         @(negedge clk);
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL resetmid_pre_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({seldig3, disp3, dp3, tick3, seldig4, disp4, dp4, tick4} !==
          {3'h7, 7'h7F, 1'b1, 1'b0, 4'hF, 7'h00, 1'b0, 1'b0}) begin
         failures++; $display("FAIL resetmid_values got3=%h got4=%h", {seldig3, disp3, dp3, tick3}, {seldig4, disp4, dp4, tick4});
      end
      rst = 1'b0;
      for (int t = 0; t < 49; t++) begin
         @(negedge clk);
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL resetmid_post_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
         if (t % 16 == 0) begin
            checks++;
            if (seldig3 !== seq[t / 16]) begin
               failures++; $display("FAIL resetmid_order t=%0d got=%b exp=%b", t, seldig3, seq[t / 16]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         checks++;
         if ({4'hF, seldig4, disp4, dp4, tick4} !== exp4) begin
            failures++; $display("FAIL random_dut4 t=%0d got=%h exp=%h", t, {4'hF, seldig4, disp4, dp4, tick4}, exp4);
         end
         checks++;
         if ({5'h1F, seldig3, disp3, dp3, tick3} !== exp3) begin
            failures++; $display("FAIL random_dut3 t=%0d got=%h exp=%h", t, {5'h1F, seldig3, disp3, dp3, tick3}, exp3);
         end
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 29) == 0) dig = 16'($urandom);
         if ($urandom_range(0, 39) == 0) dpi = 4'($urandom);
         if ($urandom_range(0, 39) == 0) blk = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 49) == 0) br = 4'($urandom);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_1234();
      test_shadow_midframe();
      test_brightness();
      test_blank_dp();
`ifdef DISPMUX_LZB_EN
      test_lzb();
`endif
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
